// File: rtl/gpio_irq_pkg.sv
// Shared types and helpers for the gpio_irq register block.
package gpio_irq_pkg;

  // Which register the current bus address points at.
  typedef enum logic [3:0] {
    SEL_VERSION,
    SEL_INPUT,
    SEL_OUTPUT,
    SEL_DIR,
    SEL_RISE_EN,
    SEL_FALL_EN,
    SEL_EVENT,
    SEL_TOGGLE,
    SEL_NONE
  } reg_sel_e;

  // Number of bus bytes needed to hold an IO vector of the given width.
  function automatic int calc_bytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/gpio_irq_core.sv
// gpio_irq register core: control registers, input synchroniser,
// edge detection, sticky event flags and the IRQ summary.
module gpio_irq_core
  import gpio_irq_pkg::*;
#(
  parameter int                  IO_WIDTH     = 8,
  parameter logic [IO_WIDTH-1:0] IO_DIRECTION = '0,
  parameter logic [IO_WIDTH-1:0] IO_TRI       = '0
) (
  input  logic                clk,
  input  logic                srst,
  input  logic [15:0]         ip_add,
  input  logic                ip_rd,
  input  logic                ip_wr,
  input  logic [7:0]          ip_din,
  output logic [7:0]          ip_dout,
  output logic                ip_dout_valid,
  input  logic [IO_WIDTH-1:0] io_in,
  output logic [IO_WIDTH-1:0] io_out,
  output logic [IO_WIDTH-1:0] io_dir,
  output logic                irq
);

  localparam int BYTES = calc_bytes(IO_WIDTH);
  localparam int PW    = BYTES * 8;

  `include "gpio_irq_regs.vh"

  // Registers are held byte-padded; bits above IO_WIDTH are never set.
  logic [PW-1:0] out_reg, out_next;
  logic [PW-1:0] dir_reg, dir_next;
  logic [PW-1:0] rise_en_reg, rise_en_next;
  logic [PW-1:0] fall_en_reg, fall_en_next;
  logic [PW-1:0] event_reg, event_next;
  logic [PW-1:0] sync1_reg, sync2_reg, prev_reg;
  logic [7:0]    rd_data_reg;
  logic          rd_valid_reg;

  logic [PW-1:0] valid_mask, tri_mask, dir_rst, io_in_ext;
  logic [PW-1:0] byte_mask, wdata_full, wr_mask, wr_bits;
  logic [PW-1:0] w1c, rise, fall;
  logic [7:0]    rd_byte;
  reg_sel_e      sel;
  int            off;
  int            byte_idx;
  logic          soft_rst;
  logic          rst_all;

  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_bit
      if (gi < IO_WIDTH) begin : g_io
        assign valid_mask[gi] = 1'b1;
        assign tri_mask[gi]   = IO_TRI[gi];
        assign dir_rst[gi]    = IO_DIRECTION[gi];
        assign io_in_ext[gi]  = io_in[gi];
        assign io_out[gi]     = out_reg[gi];
        assign io_dir[gi]     = dir_reg[gi];
      end else begin : g_pad
        assign valid_mask[gi] = 1'b0;
        assign tri_mask[gi]   = 1'b0;
        assign dir_rst[gi]    = 1'b0;
        assign io_in_ext[gi]  = 1'b0;
      end
    end
  endgenerate

  // Address decode: pick the register and the byte lane within it.
  always_comb begin
    off      = int'(ip_add);
    sel      = SEL_NONE;
    byte_idx = 0;
    if (off == REG_VERSION) begin
      sel = SEL_VERSION;
    end else if (off >= REG_INPUT && off < REG_INPUT + BYTES) begin
      sel = SEL_INPUT;   byte_idx = off - REG_INPUT;
    end else if (off >= REG_OUTPUT && off < REG_OUTPUT + BYTES) begin
      sel = SEL_OUTPUT;  byte_idx = off - REG_OUTPUT;
    end else if (off >= REG_DIR && off < REG_DIR + BYTES) begin
      sel = SEL_DIR;     byte_idx = off - REG_DIR;
    end else if (off >= REG_RISE_EN && off < REG_RISE_EN + BYTES) begin
      sel = SEL_RISE_EN; byte_idx = off - REG_RISE_EN;
    end else if (off >= REG_FALL_EN && off < REG_FALL_EN + BYTES) begin
      sel = SEL_FALL_EN; byte_idx = off - REG_FALL_EN;
    end else if (off >= REG_EVENT && off < REG_EVENT + BYTES) begin
      sel = SEL_EVENT;   byte_idx = off - REG_EVENT;
    end else if (off >= REG_TOGGLE && off < REG_TOGGLE + BYTES) begin
      sel = SEL_TOGGLE;  byte_idx = off - REG_TOGGLE;
    end
  end

  // Spread the write byte across the lane it targets; pad bits are masked off.
  always_comb begin
    byte_mask                  = '0;
    byte_mask[byte_idx*8 +: 8] = 8'hff;
    wdata_full                 = {BYTES{ip_din}};
    wr_mask                    = byte_mask & valid_mask;
    wr_bits                    = wdata_full & wr_mask;
  end

  // Register updates and edge detection; a new edge beats a same-cycle clear.
  always_comb begin
    out_next     = out_reg;
    dir_next     = dir_reg;
    rise_en_next = rise_en_reg;
    fall_en_next = fall_en_reg;
    w1c          = '0;
    if (ip_wr) begin
      case (sel)
        SEL_OUTPUT:  out_next     = (out_reg & ~wr_mask) | wr_bits;
        SEL_DIR:     dir_next     = (dir_reg & ~(wr_mask & tri_mask)) | (wr_bits & tri_mask);
        SEL_RISE_EN: rise_en_next = (rise_en_reg & ~wr_mask) | wr_bits;
        SEL_FALL_EN: fall_en_next = (fall_en_reg & ~wr_mask) | wr_bits;
        SEL_EVENT:   w1c          = wr_bits;
        SEL_TOGGLE:  out_next     = out_reg ^ wr_bits;
        default:     ;
      endcase
    end
    rise       = sync2_reg & ~prev_reg & rise_en_reg;
    fall       = ~sync2_reg & prev_reg & fall_en_reg;
    event_next = (event_reg & ~w1c) | rise | fall;
  end

  // Read mux; write-only and unmapped locations read as zero.
  always_comb begin
    rd_byte = '0;
    case (sel)
      SEL_VERSION: rd_byte = VERSION;
      SEL_INPUT:   rd_byte = sync2_reg[byte_idx*8 +: 8];
      SEL_OUTPUT:  rd_byte = out_reg[byte_idx*8 +: 8];
      SEL_DIR:     rd_byte = dir_reg[byte_idx*8 +: 8];
      SEL_RISE_EN: rd_byte = rise_en_reg[byte_idx*8 +: 8];
      SEL_FALL_EN: rd_byte = fall_en_reg[byte_idx*8 +: 8];
      SEL_EVENT:   rd_byte = event_reg[byte_idx*8 +: 8];
      default:     rd_byte = '0;
    endcase
  end

  // A write to the VERSION location acts exactly like the external reset.
  assign soft_rst = ip_wr && (sel == SEL_VERSION);
  assign rst_all  = srst || soft_rst;

  // State registers, input synchroniser chain and registered read data.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      out_reg      <= '0;
      dir_reg      <= dir_rst;
      rise_en_reg  <= '0;
      fall_en_reg  <= '0;
      event_reg    <= '0;
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      prev_reg     <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      out_reg      <= out_next;
      dir_reg      <= dir_next;
      rise_en_reg  <= rise_en_next;
      fall_en_reg  <= fall_en_next;
      event_reg    <= event_next;
      sync1_reg    <= io_in_ext;
      sync2_reg    <= sync1_reg;
      prev_reg     <= sync2_reg;
      rd_valid_reg <= ip_rd;
      if (ip_rd) begin
        rd_data_reg <= rd_byte;
      end
    end
  end

  assign ip_dout       = rd_data_reg;
  assign ip_dout_valid = rd_valid_reg;
  assign irq           = |event_reg;

endmodule

// File: rtl/gpio_irq_regs.vh
// Register byte offsets inside the gpio_irq window.
// Included inside a module body where BYTES is already defined.
localparam int REG_VERSION = 0;
localparam int REG_INPUT   = 1 + 0 * BYTES;
localparam int REG_OUTPUT  = 1 + 1 * BYTES;
localparam int REG_DIR     = 1 + 2 * BYTES;
localparam int REG_RISE_EN = 1 + 3 * BYTES;
localparam int REG_FALL_EN = 1 + 4 * BYTES;
localparam int REG_EVENT   = 1 + 5 * BYTES;
localparam int REG_TOGGLE  = 1 + 6 * BYTES;
localparam logic [7:0] VERSION = 8'd1;

// File: rtl/gpio_irq.sv
// gpio_irq top: address window decode onto the IP side, register core,
// and the tristate drivers for the data bus and the IO pads.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter logic [15:0]         BASEADDR     = 16'h0000,
  parameter logic [15:0]         HIGHADDR     = 16'h001f,
  parameter int                  IO_WIDTH     = 8,
  parameter logic [IO_WIDTH-1:0] IO_DIRECTION = '0,
  parameter logic [IO_WIDTH-1:0] IO_TRI       = '0
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST,
  input  logic [15:0]         BUS_ADD,
  inout  wire  [7:0]          BUS_DATA,
  input  logic                BUS_RD,
  input  logic                BUS_WR,
  inout  wire  [IO_WIDTH-1:0] IO,
  output logic                IRQ
);

  localparam logic [15:0] SPAN = HIGHADDR - BASEADDR;

  logic [15:0]         ip_add;
  logic                cs;
  logic                ip_rd;
  logic                ip_wr;
  logic [7:0]          ip_dout;
  logic                ip_dout_valid;
  logic [IO_WIDTH-1:0] io_out;
  logic [IO_WIDTH-1:0] io_dir;

  // Addresses below BASEADDR wrap to large offsets and fall outside SPAN.
  assign ip_add = BUS_ADD - BASEADDR;
  assign cs     = (ip_add <= SPAN);
  assign ip_rd  = BUS_RD & cs;
  assign ip_wr  = BUS_WR & cs;

  // Data bus is driven only in the cycle carrying registered read data.
  assign BUS_DATA = ip_dout_valid ? ip_dout : 8'hzz;

  gpio_irq_core #(
    .IO_WIDTH     (IO_WIDTH),
    .IO_DIRECTION (IO_DIRECTION),
    .IO_TRI       (IO_TRI)
  ) u_core (
    .clk           (BUS_CLK),
    .srst          (BUS_RST),
    .ip_add        (ip_add),
    .ip_rd         (ip_rd),
    .ip_wr         (ip_wr),
    .ip_din        (BUS_DATA),
    .ip_dout       (ip_dout),
    .ip_dout_valid (ip_dout_valid),
    .io_in         (IO),
    .io_out        (io_out),
    .io_dir        (io_dir),
    .irq           (IRQ)
  );

  genvar gi;
  generate
    for (gi = 0; gi < IO_WIDTH; gi++) begin : g_pad
      assign IO[gi] = io_dir[gi] ? io_out[gi] : 1'bz;
    end
  endgenerate

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq with a 16-bit IO, low byte outputs,
// high byte runtime-switchable, and the high byte looped back from the low.
module tb_gpio_irq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] add = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  wdata = '0;
  logic        drv_en = 1'b0;
  logic        irq;
  wire  [7:0]  bus_data;
  wire  [15:0] io;

  logic        tie_en = 1'b1;
  logic [7:0]  hi_copy = '0;
  logic        rd_d = 1'b0;

  typedef struct {
    string      name;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs_q[$];
  int         tests_run = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  assign bus_data = drv_en ? wdata : 8'hzz;
  // Loopback: high pad byte follows the low byte, resampled half a cycle later.
  always @(negedge clk) hi_copy <= io[7:0];
  assign io[15:8] = tie_en ? hi_copy : 8'hzz;

  gpio_irq #(
    .BASEADDR     (16'h0000),
    .HIGHADDR     (16'h001f),
    .IO_WIDTH     (16),
    .IO_DIRECTION (16'h00ff),
    .IO_TRI       (16'hff00)
  ) dut (
    .BUS_CLK  (clk),
    .BUS_RST  (rst),
    .BUS_ADD  (add),
    .BUS_DATA (bus_data),
    .BUS_RD   (rd),
    .BUS_WR   (wr),
    .IO       (io),
    .IRQ      (irq)
  );

  // Read data is valid on the bus in the cycle after the read strobe.
  always @(posedge clk) rd_d <= rd;
  always @(negedge clk) if (rd_d) obs_q.push_back(bus_data);

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    if (rd_d) @(negedge clk);
    add = a; wdata = d; drv_en = 1'b1; wr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; drv_en = 1'b0;
    $display("[TB] write off=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [7:0] e, input string n);
    exp_t x;
    x.name = n; x.data = e;
    exp_q.push_back(x);
    add = a; rd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    exp_t x;
    logic [7:0] o;
    tests_run++;
    if (irq !== 1'b0) begin failed++; $display("FAIL reset_irq got %b want 0", irq); end
    tests_run++;
    if (io[7:0] !== 8'h00) begin failed++; $display("FAIL reset_io got %h want 00", io[7:0]); end
    for (int i = 0; i <= 14; i++) begin
      bus_read(16'(i), (i == 0) ? 8'h01 : ((i == 5) ? 8'hff : 8'h00), "reset_map");
    end
    bus_read(16'd15, 8'h00, "beyond_map15");
    bus_read(16'd31, 8'h00, "beyond_map31");
    @(negedge clk);
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s got no data want %h", x.name, x.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== x.data) begin failed++; $display("FAIL %s got %h want %h", x.name, o, x.data); end
        else $display("[TB] %s read %h ok", x.name, o);
      end
    end
  endtask

  task automatic test_output();
    exp_t x;
    logic [7:0] o;
    bus_write(16'd3, 8'ha5);
    bus_write(16'd4, 8'h5a);
    bus_write(16'd15, 8'hff);
    tests_run++;
    if (io[7:0] !== 8'ha5) begin failed++; $display("FAIL output_pad got %h want a5", io[7:0]); end
    repeat (4) @(negedge clk);
    bus_read(16'd1, 8'ha5, "input_lo");
    bus_read(16'd2, 8'ha5, "input_hi_loop");
    bus_read(16'd3, 8'ha5, "output_lo");
    bus_read(16'd4, 8'h5a, "output_hi");
    bus_read(16'd15, 8'h00, "unmapped_write_ignored");
    @(negedge clk);
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s got no data want %h", x.name, x.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== x.data) begin failed++; $display("FAIL %s got %h want %h", x.name, o, x.data); end
        else $display("[TB] %s read %h ok", x.name, o);
      end
    end
  endtask

  task automatic test_dir_mask();
    exp_t x;
    logic [7:0] o;
    tie_en = 1'b0;
    bus_write(16'd6, 8'hff);
    bus_write(16'd5, 8'h00);
    tests_run++;
    if (io[15:8] !== 8'h5a) begin failed++; $display("FAIL dir_hi_drive got %h want 5a", io[15:8]); end
    repeat (3) @(negedge clk);
    bus_read(16'd5, 8'hff, "dir_lo_fixed");
    bus_read(16'd6, 8'hff, "dir_hi_writable");
    bus_read(16'd2, 8'h5a, "input_hi_driven");
    bus_write(16'd6, 8'h00);
    tie_en = 1'b1;
    bus_read(16'd6, 8'h00, "dir_hi_restored");
    @(negedge clk);
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s got no data want %h", x.name, x.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== x.data) begin failed++; $display("FAIL %s got %h want %h", x.name, o, x.data); end
        else $display("[TB] %s read %h ok", x.name, o);
      end
    end
  endtask

  task automatic test_events();
    exp_t x;
    logic [7:0] o;
    bus_write(16'd3, 8'h00);
    bus_write(16'd4, 8'h00);
    repeat (4) @(negedge clk);
    bus_write(16'd7, 8'h01);
    bus_write(16'd8, 8'h00);
    bus_write(16'd9, 8'h00);
    bus_write(16'd10, 8'h01);
    repeat (2) @(negedge clk);
    bus_write(16'd13, 8'h01);
    @(negedge clk);
    tests_run++;
    if (irq !== 1'b0) begin failed++; $display("FAIL irq_early1 got %b want 0", irq); end
    @(negedge clk);
    tests_run++;
    if (irq !== 1'b0) begin failed++; $display("FAIL irq_early2 got %b want 0", irq); end
    @(negedge clk);
    tests_run++;
    if (irq !== 1'b1) begin failed++; $display("FAIL irq_latency got %b want 1", irq); end
    bus_read(16'd11, 8'h01, "event_rise_lo");
    bus_read(16'd12, 8'h00, "event_rise_hi");
    bus_read(16'd13, 8'h00, "toggle_reads_zero");
    bus_write(16'd13, 8'h01);
    repeat (4) @(negedge clk);
    bus_read(16'd11, 8'h01, "event_fall_lo");
    bus_read(16'd12, 8'h01, "event_fall_hi");
    bus_write(16'd11, 8'h01);
    tests_run++;
    if (irq !== 1'b1) begin failed++; $display("FAIL irq_after_w1c got %b want 1", irq); end
    bus_read(16'd11, 8'h00, "event_w1c_lo");
    bus_read(16'd12, 8'h01, "event_w1c_hi");
    bus_write(16'd10, 8'h00);
    bus_read(16'd12, 8'h01, "event_kept_after_disable");
    bus_write(16'd10, 8'h01);
    @(negedge clk);
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s got no data want %h", x.name, x.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== x.data) begin failed++; $display("FAIL %s got %h want %h", x.name, o, x.data); end
        else $display("[TB] %s read %h ok", x.name, o);
      end
    end
  endtask

  task automatic test_w1c_collision();
    exp_t x;
    logic [7:0] o;
    // Pad bit 0 is low here; this toggle's rising edge lands on EVENT three edges later.
    bus_write(16'd13, 8'h01);
    repeat (2) @(negedge clk);
    bus_write(16'd11, 8'h01);
    @(negedge clk);
    bus_read(16'd11, 8'h01, "edge_beats_w1c");
    bus_read(16'd12, 8'h01, "collision_hi_kept");
    bus_write(16'd11, 8'h01);
    bus_read(16'd11, 8'h00, "plain_w1c");
    @(negedge clk);
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s got no data want %h", x.name, x.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== x.data) begin failed++; $display("FAIL %s got %h want %h", x.name, o, x.data); end
        else $display("[TB] %s read %h ok", x.name, o);
      end
    end
  endtask

  task automatic test_soft_reset();
    exp_t x;
    logic [7:0] o;
    bus_write(16'd3, 8'hc3);
    tests_run++;
    if (irq !== 1'b1) begin failed++; $display("FAIL pre_soft_irq got %b want 1", irq); end
    tests_run++;
    if (io[7:0] !== 8'hc3) begin failed++; $display("FAIL pre_soft_io got %h want c3", io[7:0]); end
    bus_write(16'd0, 8'h5a);
    @(negedge clk);
    tests_run++;
    if (irq !== 1'b0) begin failed++; $display("FAIL soft_irq got %b want 0", irq); end
    tests_run++;
    if (io[7:0] !== 8'h00) begin failed++; $display("FAIL soft_io got %h want 00", io[7:0]); end
    bus_read(16'd3, 8'h00, "soft_output");
    bus_read(16'd5, 8'hff, "soft_dir_lo");
    bus_read(16'd6, 8'h00, "soft_dir_hi");
    bus_read(16'd7, 8'h00, "soft_rise_en");
    bus_read(16'd10, 8'h00, "soft_fall_en");
    bus_read(16'd11, 8'h00, "soft_event_lo");
    bus_read(16'd12, 8'h00, "soft_event_hi");
    @(negedge clk);
    while (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL %s got no data want %h", x.name, x.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== x.data) begin failed++; $display("FAIL %s got %h want %h", x.name, o, x.data); end
        else $display("[TB] %s read %h ok", x.name, o);
      end
    end
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_output();
    test_dir_mask();
    test_events();
    test_w1c_collision();
    test_soft_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
